// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Covers the state codes, opcode/funct values and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeq     = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StJal     = 4'd12,
        StJr      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // States that hold a memory access open and wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-state counter for memory accesses; flags a timeout after WAIT_MAX
// consecutive not-ready cycles. Saturates instead of wrapping.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic timeout
);

    localparam logic [CNT_W-1:0] Limit  = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = active && !ready && (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !active || ready || timeout) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over several
// cycles, with a memory ready handshake, wait-state timeout and illegal-op flag.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       jal,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   timeout;
    logic   clear;
    logic   op_legal;

    assign op_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                      (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J) ||
                      (opcode == OP_JAL);

    // A timeout in FETCH keeps the state but must still restart the count.
    assign clear = (state_d != state_q);

    mc_wait_timer #(
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .active (is_mem_state(state_q)),
        .ready  (mem_ready),
        .clear  (clear),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (mem_ready)    state_d = StDecode;
                else if (timeout) state_d = StFetch;
            end
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = (funct == FUNCT_JR) ? StJr : StRtypeEx;
                    OP_BEQ:       state_d = StBeq;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    OP_JAL:       state_d = StJal;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StFetch;
            end
            StMemWr: begin
                if (mem_ready || timeout) state_d = StFetch;
            end
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pcwrite    = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        jal        = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        aluop      = ALUOP_ADD;
        pcsrc      = PCSRC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        state      = 4'd0;
        if (!rst) begin
            state   = state_q;
            mem_err = timeout;
            case (state_q)
                StFetch: begin
                    memread = 1'b1;
                    alusrcb = SRCB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                StDecode: begin
                    alusrcb = SRCB_IMM_SH;
                    illegal = !op_legal;
                end
                StMemAdr: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                StMemRd: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                StMemWb: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    instr_done = 1'b1;
                end
                StMemWr: begin
                    memwrite   = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                StRtypeEx: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                StRtypeWb: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    instr_done = 1'b1;
                end
                StBeq: begin
                    alusrca    = 1'b1;
                    aluop      = ALUOP_SUB;
                    pcsrc      = PCSRC_ALUOUT;
                    pcwrite    = zero;
                    instr_done = 1'b1;
                end
                StAddiEx: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                StAddiWb: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                StJump: begin
                    pcsrc      = PCSRC_JUMP;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                StJal: begin
                    pcsrc      = PCSRC_JUMP;
                    pcwrite    = 1'b1;
                    regwrite   = 1'b1;
                    jal        = 1'b1;
                    instr_done = 1'b1;
                end
                StJr: begin
                    pcsrc      = PCSRC_RS;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
